// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: state encoding and width helper.
package fifo_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'b000;
  localparam state_t WRITE    = 3'b001;
  localparam state_t READ     = 3'b010;
  localparam state_t WR_ERROR = 3'b011;
  localparam state_t RD_ERROR = 3'b100;
  localparam state_t WR_RD    = 3'b101;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ptr_cal.sv
// Next-pointer and occupancy calculation for the FIFO, driven by the decoded operation.
module fifo_ptr_cal
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  state_t                state,
  input  logic [ADDR_WIDTH-1:0] head,
  input  logic [ADDR_WIDTH-1:0] tail,
  input  logic [ADDR_WIDTH:0]   data_count,
  output logic [ADDR_WIDTH-1:0] next_head,
  output logic [ADDR_WIDTH-1:0] next_tail,
  output logic [ADDR_WIDTH:0]   next_data_count,
  output logic                  we,
  output logic                  re
);

  always_comb begin
    we = (state == WRITE) || (state == WR_RD);
    // A combined request on an empty FIFO only writes; there is no bypass path.
    re = (state == READ) || ((state == WR_RD) && (data_count != '0));

    next_head       = re ? head + 1'b1 : head;
    next_tail       = we ? tail + 1'b1 : tail;
    next_data_count = data_count;
    if (we && !re) begin
      next_data_count = data_count + 1'b1;
    end else if (re && !we) begin
      next_data_count = data_count - 1'b1;
    end
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy flags and registered ack/err handshakes.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AFULL_LVL  = 6,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [ADDR_WIDTH:0]   data_count
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int CNT_WIDTH = clog2(DEPTH) + 1;

  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AFULL_C  = CNT_WIDTH'(AFULL_LVL);
  localparam logic [CNT_WIDTH-1:0] AEMPTY_C = CNT_WIDTH'(AEMPTY_LVL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] head_reg, head_next;
  logic [ADDR_WIDTH-1:0] tail_reg, tail_next;
  logic [CNT_WIDTH-1:0]  count_reg, count_next;
  logic [DATA_WIDTH-1:0] dout_reg;
  state_t                state_reg, state_next;
  logic                  rd_miss_reg;
  logic                  we, re;

  always_comb begin
    state_next = IDLE;
    if (wr_en && rd_en) begin
      state_next = WR_RD;
    end else if (wr_en) begin
      state_next = full ? WR_ERROR : WRITE;
    end else if (rd_en) begin
      state_next = empty ? RD_ERROR : READ;
    end
  end

  fifo_ptr_cal #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ptr_cal (
    .state           (state_next),
    .head            (head_reg),
    .tail            (tail_reg),
    .data_count      (count_reg),
    .next_head       (head_next),
    .next_tail       (tail_next),
    .next_data_count (count_next),
    .we              (we),
    .re              (re)
  );

  // Storage has no reset so it maps onto block RAM; reset still blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      mem[tail_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      dout_reg    <= '0;
      state_reg   <= IDLE;
      rd_miss_reg <= 1'b0;
    end else begin
      head_reg    <= head_next;
      tail_reg    <= tail_next;
      count_reg   <= count_next;
      state_reg   <= state_next;
      rd_miss_reg <= (state_next == WR_RD) && !re;
      if (re) begin
        dout_reg <= mem[head_reg];
      end
    end
  end

  // Handshakes come straight from registered state, so each is a one-cycle pulse.
  assign wr_ack = (state_reg == WRITE) || (state_reg == WR_RD);
  assign wr_err = (state_reg == WR_ERROR);
  assign rd_ack = (state_reg == READ) || ((state_reg == WR_RD) && !rd_miss_reg);
  assign rd_err = (state_reg == RD_ERROR) || ((state_reg == WR_RD) && rd_miss_reg);

  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AFULL_C);
  assign almost_empty = (count_reg <= AEMPTY_C);
  assign data_count   = count_reg;
  assign dout         = dout_reg;

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO. Generalises the fixed 8-entry FIFO in width, depth and status flags.
- Adds simultaneous read+write, almost-full/almost-empty thresholds and registered error/ack handshakes.
- Sits between a producer and a consumer in the same clock domain.
- Storage, pointer/count calculation and state register are contained in one block.

Parameters:
- DATA_WIDTH, 32, width of each entry.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (default 8).
- AFULL_LVL, 6, almost_full asserted when data_count >= AFULL_LVL.
- AEMPTY_LVL, 2, almost_empty asserted when data_count <= AEMPTY_LVL.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- din  in  DATA_WIDTH  write data, sampled when a write is accepted.
- dout  out  DATA_WIDTH  registered read data.
- full  out  1  data_count == DEPTH.
- empty  out  1  data_count == 0.
- almost_full  out  1  data_count >= AFULL_LVL.
- almost_empty  out  1  data_count <= AEMPTY_LVL.
- wr_ack  out  1  previous-cycle write accepted.
- wr_err  out  1  previous-cycle write rejected (full).
- rd_ack  out  1  previous-cycle read accepted; dout valid this cycle.
- rd_err  out  1  previous-cycle read rejected (empty).
- data_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (sampled at clk edge while reset=1):
  - head=0, tail=0, data_count=0, dout=0, state=IDLE.
  - All handshakes 0; empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not cleared.
  - Reset has priority over wr_en/rd_en in the same cycle. A mid-operation reset discards all contents.
- States are registered, decoded from wr_en, rd_en, full and empty in the current cycle:
  - IDLE: no request.
  - WRITE: wr_en and not full.
  - READ: rd_en and not empty.
  - WR_RD: both requests; see rules below.
  - WR_ERROR: wr_en, full, and no read.
  - RD_ERROR: rd_en, empty, and no write.
- Write accepted: mem[tail] <= din; tail+1 wraps modulo DEPTH; data_count+1.
- Read accepted: dout <= mem[head]; head+1 wraps modulo DEPTH; data_count-1.
- Read latency is 1 cycle: data appears on dout together with rd_ack in the cycle after rd_en.
- dout holds its last value whenever no read is accepted.
- Simultaneous wr_en & rd_en:
  - Neither full nor empty: both accepted; data_count unchanged; wr_ack=rd_ack=1.
  - Full: both accepted; the read frees the slot that the write fills. data_count stays DEPTH; no wr_err.
  - Empty: write accepted; read rejected (no write-through bypass). rd_err=1, wr_ack=1, data_count becomes 1.
- Rejected operation: pointers, count, dout and memory are unchanged; the matching err flag pulses 1 cycle.
- Flags:
  - full, empty, almost_* are combinational from the registered data_count; never both full and empty.
  - All ack/err flags are single-cycle registered pulses, cleared to 0 in any cycle without the matching event.
- Arithmetic:
  - Pointers are ADDR_WIDTH bits with natural wrap.
  - data_count is one bit wider, so DEPTH is representable; it never exceeds DEPTH or goes below 0.

Decomposition:
- Package fifo_pkg:
  - state encoding localparams: IDLE=3'b000, WRITE=3'b001, READ=3'b010, WR_ERROR=3'b011, RD_ERROR=3'b100, WR_RD=3'b101.
  - Function clog2 for derived widths.
- One sub-module, fifo_ptr_cal:
  - Combinational next_head/next_tail/next_data_count/we/re from state, head, tail, data_count.
  - Parametrised on ADDR_WIDTH.
- Storage is an inferred register array in the top level.

Test Plan:
- Reset, then rd_en=1 for 1 cycle -> rd_err=1 next cycle, empty=1, data_count=0, dout=0.
- Write 8 words 0xA0..0xA7 (default params) -> full=1, data_count=8, almost_full first high after the 6th write. A 9th write gives wr_err=1, count stays 8.
- From full, read 8 words -> dout sequence 0xA0..0xA7, each with rd_ack=1 one cycle after rd_en. Then empty=1; almost_empty high once count<=2.
- Pointer wrap: write 5, read 5, write 6, read 6 -> data in order; head=tail=3 at end; count=0.
- Simultaneous wr_en/rd_en:
  - At count=4: count stays 4; both acks set.
  - At full: count stays 8; oldest word is read out.
  - At empty: wr_ack=1, rd_err=1, count=1.
- Assert reset during a burst at count=5 -> next cycle count=0, empty=1, all acks/errs 0, dout=0.
